// File: rtl/gf2_poly_reducer.sv
// gf2_poly_reducer: sequential GF(2)[x] reducer computing c mod f(x), f(x) = x^N + POLY(x).
// Eliminates D product coefficients per RUN cycle, high to low, and returns the
// N-bit remainder through a registered valid/ready output.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-low reset
//   in_valid   - in_prod holds a product to reduce
//   in_ready   - block is idle and can accept a product (decoded from state)
//   in_prod    - 2N-bit carry-less product, bit i = coefficient of x^i
//   out_valid  - out_rem holds a finished remainder (registered)
//   out_ready  - consumer accepts out_rem
//   out_rem    - N-bit remainder (registered)
//   busy       - high while an operation is in RUN or DONE
module gf2_poly_reducer #(
    parameter int unsigned N    = 384,
    parameter logic [N-1:0] POLY = N'('h100D),
    parameter int unsigned D    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_prod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_rem,
    output logic           busy
);

    localparam int unsigned IW    = 2 * N;
    localparam int unsigned STEPS = N / D;
    localparam int unsigned CW    = $clog2(STEPS) + 1;
    localparam int unsigned JW    = $clog2(IW);

    // Full modulus x^N + POLY, zero-extended to the working register width.
    localparam logic [IW-1:0] POLY_FULL = IW'({1'b1, POLY});

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_r;
    logic [IW-1:0]   w_r_step;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [N-1:0]    r_out_rem;
    logic [JW-1:0]   w_j;
    logic            w_last;

    assign w_last    = (r_cnt == CW'(STEPS - 1));
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_rem   = r_out_rem;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE releases only after the registered output is handed off.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)                  w_state_next = S_RUN;
            S_RUN:  if (w_last)                    w_state_next = S_DONE;
            S_DONE: if (r_out_valid && out_ready)  w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    // One digit of elimination: D leading coefficients, each step seeing the previous XOR.
    always_comb begin
        w_r_step = r_r;
        w_j      = '0;
        for (int unsigned k = 0; k < D; k++) begin
            w_j = JW'(IW - 1 - 32'(r_cnt) * D - k);
            if (w_r_step[w_j]) begin
                w_r_step = w_r_step ^ (POLY_FULL << (w_j - JW'(N)));
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_r         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_r   <= in_prod;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    if (r_out_valid) begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end else begin
                        // Upper half is already zero here; publish the remainder.
                        r_out_valid <= 1'b1;
                        r_out_rem   <= r_r[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_reducer.sv
module tb_gf2_poly_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic our;

    logic         iv1, ir1, ov1, bz1;
    logic [15:0]  ip1;
    logic [7:0]   rem1;
    logic         iv2, ir2, ov2, bz2;
    logic [15:0]  ip2;
    logic [7:0]   rem2;
    logic         iv4, ir4, ov4, bz4;
    logic [767:0] ip4;
    logic [383:0] rem4;

    int n_err = 0;
    int n_chk = 0;

    gf2_poly_reducer #(.N(8), .POLY(8'h1B), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_prod(ip1),
        .out_valid(ov1), .out_ready(our), .out_rem(rem1), .busy(bz1)
    );

    gf2_poly_reducer #(.N(8), .POLY(8'h1B), .D(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_prod(ip2),
        .out_valid(ov2), .out_ready(our), .out_rem(rem2), .busy(bz2)
    );

    gf2_poly_reducer u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_prod(ip4),
        .out_valid(ov4), .out_ready(our), .out_rem(rem4), .busy(bz4)
    );

    // Single comparison point.
    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return ov1;
            1:       return ov2;
            default: return ov4;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            0:       return ir1;
            1:       return ir2;
            default: return ir4;
        endcase
    endfunction

    function automatic logic get_bz(input int sel);
        case (sel)
            0:       return bz1;
            1:       return bz2;
            default: return bz4;
        endcase
    endfunction

    function automatic logic [383:0] get_rem(input int sel);
        case (sel)
            0:       return 384'(rem1);
            1:       return 384'(rem2);
            default: return rem4;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [767:0] p);
        case (sel)
            0:       begin iv1 = v; ip1 = p[15:0]; end
            1:       begin iv2 = v; ip2 = p[15:0]; end
            default: begin iv4 = v; ip4 = p;       end
        endcase
    endtask

    // Reference: Horner evaluation of c(x) mod f, shifting in one coefficient at a time
    // and folding x^n back as POLY whenever the remainder overflows degree n-1.
    function automatic logic [383:0] ref_mod(input logic [767:0] p, input int n,
                                             input logic [383:0] poly);
        logic [383:0] rem;
        logic [383:0] mask;
        logic [383:0] top;
        logic [767:0] pt;
        rem  = '0;
        mask = '1;
        mask = mask >> (384 - n);
        for (int i = 2 * n - 1; i >= 0; i--) begin
            top = rem >> (n - 1);
            pt  = p >> i;
            rem = (rem << 1) & mask;
            if (top[0]) rem = rem ^ poly;
            rem[0] = rem[0] ^ pt[0];
        end
        return rem;
    endfunction

    function automatic logic [15:0] clmul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) acc = acc ^ (16'(b) << i);
        end
        return acc;
    endfunction

    // Present a product for one edge; returns at #1 after the accept edge.
    task automatic start(input int sel, input logic [767:0] p);
        set_in(sel, 1'b1, p);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, '0);
    endtask

    // Counts edges after the accept edge until out_valid is seen, with a bound.
    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (get_ov(sel) !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (get_ov(sel) !== 1'b1) chk("timeout_out_valid", 384'(get_ov(sel)), 384'(1));
    endtask

    // Full transaction with out_ready high; ends idle at #1 after the transfer edge.
    task automatic do_op(input int sel, input logic [767:0] p,
                         output logic [383:0] rem, output int lat);
        start(sel, p);
        wait_valid(sel, lat);
        rem = get_rem(sel);
        @(posedge clk);
        #1;
    endtask

    logic [15:0]  vin  [5] = '{16'h2B79, 16'h0100, 16'h8000, 16'h00AB, 16'h0000};
    logic [7:0]   vexp [5] = '{8'hC1, 8'h1B, 8'h2F, 8'hAB, 8'h00};

    initial begin
        logic [383:0] rem;
        logic [383:0] held;
        logic [767:0] p;
        logic [383:0] poly384;
        int           lat;
        int           seen;

        poly384 = 384'h100D;
        rst = 1'b0;
        our = 1'b1;
        set_in(0, 1'b1, 16'h2B79);
        set_in(1, 1'b0, '0);
        set_in(2, 1'b0, '0);

        // Reset: in_valid on reset edges must be ignored.
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_out_valid_%0d", s), 384'(get_ov(s)), 384'(0));
            chk($sformatf("rst_busy_%0d", s), 384'(get_bz(s)), 384'(0));
            chk($sformatf("rst_out_rem_%0d", s), get_rem(s), 384'(0));
        end
        set_in(0, 1'b0, '0);
        rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_in_ready_%0d", s), 384'(get_ir(s)), 384'(1));
        end

        // Directed vectors on D=1 and D=2.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 5; v++) begin
                do_op(s, 768'(vin[v]), rem, lat);
                chk($sformatf("vec_rem_d%0d_%0d", s + 1, v), rem, 384'(vexp[v]));
                chk($sformatf("vec_lat_d%0d_%0d", s + 1, v), 384'(lat), 384'(s == 0 ? 9 : 5));
            end
        end

        // Random 15-bit products against the reference on D=2.
        for (int t = 0; t < 1000; t++) begin
            logic [15:0] pr;
            pr = clmul8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            do_op(1, 768'(pr), rem, lat);
            chk($sformatf("rand8_rem_%0d_%h", t, pr), rem, ref_mod(768'(pr), 8, 384'h1B));
            chk($sformatf("rand8_lat_%0d", t), 384'(lat), 384'(5));
        end

        // Backpressure: hold the result for 20 cycles with a second product pending.
        our = 1'b0;
        start(1, 768'(16'h2B79));
        wait_valid(1, lat);
        held = get_rem(1);
        chk("bp_rem", held, 384'hC1);
        set_in(1, 1'b1, 768'(16'h0100));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_%0d", c), 384'(ov2), 384'(1));
            chk($sformatf("bp_stable_%0d", c), 384'(rem2), held);
            chk($sformatf("bp_in_ready_%0d", c), 384'(ir2), 384'(0));
        end
        our = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_xfer_valid_low", 384'(ov2), 384'(0));
        chk("bp_xfer_in_ready", 384'(ir2), 384'(1));
        @(posedge clk);
        #1;
        set_in(1, 1'b0, '0);
        chk("bp_second_accepted", 384'(bz2), 384'(1));
        wait_valid(1, lat);
        chk("bp_second_rem", get_rem(1), 384'h1B);
        chk("bp_second_lat", 384'(lat), 384'(5));
        @(posedge clk);
        #1;

        // Reset during RUN cycle 3 discards the operation.
        start(1, 768'(16'h8000));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_out_valid", 384'(ov2), 384'(0));
        chk("abort_busy", 384'(bz2), 384'(0));
        chk("abort_in_ready", 384'(ir2), 384'(1));
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (ov2 === 1'b1) seen++;
        end
        chk("abort_no_output", 384'(seen), 384'(0));
        do_op(1, 768'(16'h2B79), rem, lat);
        chk("abort_next_rem", rem, 384'hC1);
        chk("abort_next_lat", 384'(lat), 384'(5));

        // Default configuration: N=384, D=4.
        do_op(2, 768'(1), rem, lat);
        chk("n384_one_rem", rem, 384'(1));
        chk("n384_one_lat", 384'(lat), 384'(97));
        p = '0;
        p[384] = 1'b1;
        do_op(2, p, rem, lat);
        chk("n384_x384_rem", rem, 384'h100D);
        chk("n384_x384_lat", 384'(lat), 384'(97));
        for (int t = 0; t < 12; t++) begin
            for (int w = 0; w < 24; w++) p[w*32 +: 32] = $urandom();
            if (t < 3) p[767:384] = '0;
            do_op(2, p, rem, lat);
            chk($sformatf("n384_rand_rem_%0d", t), rem, ref_mod(p, 384, poly384));
            chk($sformatf("n384_rand_lat_%0d", t), 384'(lat), 384'(97));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
